// File: rtl/led_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_seq_pkg                                                        |
// | Shared encodings and initial patterns for the LED sequencer.       |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package led_seq_pkg;

  localparam int MODE_W  = 3;
  localparam int SPEED_W = 2;
  localparam int LED_W   = 4;

  localparam logic [MODE_W-1:0] MODE_OFF    = 3'd0;
  localparam logic [MODE_W-1:0] MODE_BLINK  = 3'd1;
  localparam logic [MODE_W-1:0] MODE_CHASE  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_BOUNCE = 3'd3;
  localparam logic [MODE_W-1:0] MODE_COUNT  = 3'd4;

  localparam logic [LED_W-1:0] PAT_OFF_INIT    = 4'b0000;
  localparam logic [LED_W-1:0] PAT_BLINK_INIT  = 4'b1111;
  localparam logic [LED_W-1:0] PAT_CHASE_INIT  = 4'b0001;
  localparam logic [LED_W-1:0] PAT_BOUNCE_INIT = 4'b0001;
  localparam logic [LED_W-1:0] PAT_COUNT_INIT  = 4'b0000;
  localparam logic [LED_W-1:0] PAT_BOUNCE_TOP  = 4'b1000;
  localparam logic [LED_W-1:0] PAT_BOUNCE_BOT  = 4'b0001;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } hs_state_t;

  // Reserved modes fall through to the OFF pattern.
  function automatic logic [LED_W-1:0] pattern_init(input logic [MODE_W-1:0] mode);
    case (mode)
      MODE_BLINK:  return PAT_BLINK_INIT;
      MODE_CHASE:  return PAT_CHASE_INIT;
      MODE_BOUNCE: return PAT_BOUNCE_INIT;
      MODE_COUNT:  return PAT_COUNT_INIT;
      default:     return PAT_OFF_INIT;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_pattern_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_pattern_sequencer_if                                           |
// | Mode/speed request handshake between upstream logic and sequencer. |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
interface led_pattern_sequencer_if;
  import led_seq_pkg::*;

  logic [MODE_W-1:0]  mode_in;
  logic [SPEED_W-1:0] speed_in;
  logic               mode_valid;
  logic               mode_ready;

  modport master (
    output mode_in,
    output speed_in,
    output mode_valid,
    input  mode_ready
  );

  modport slave (
    input  mode_in,
    input  speed_in,
    input  mode_valid,
    output mode_ready
  );

endinterface
`default_nettype wire

// File: rtl/led_step_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_step_prescaler                                                 |
// | Step-rate counter with pause gating and registered step_tick.      |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module led_step_prescaler
  import led_seq_pkg::*;
#(
  parameter int STEP_DIV = 25_000_000,
  parameter int CNT_W    = $clog2(STEP_DIV)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pause,
  input  logic [SPEED_W-1:0] speed,
  output logic               fire,
  output logic               step_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_terminal;
  logic             r_step_tick;

  assign w_terminal = CNT_W'((STEP_DIV >> speed) - 1);

  // '>=' recovers when a faster speed leaves the count past the new terminal.
  assign fire      = !pause && (r_cnt >= w_terminal);
  assign step_tick = r_step_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_step_tick <= 1'b0;
    end else if (pause) begin
      r_step_tick <= 1'b0;
    end else if (fire) begin
      r_cnt       <= '0;
      r_step_tick <= 1'b1;
    end else begin
      r_cnt       <= r_cnt + CNT_W'(1);
      r_step_tick <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_pattern_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_pattern_sequencer                                              |
// | Drives a 4-LED bank through OFF/BLINK/CHASE/BOUNCE/COUNT patterns, |
// | applying new mode/speed requests on step boundaries.               |
// | Optional: LED_SEQ_PWM_EN adds a brightness input and PWM dimming.  |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int STEP_DIV = 25_000_000,
  parameter int CNT_W    = $clog2(STEP_DIV)
) (
  input  logic                     clk,
  input  logic                     rst,
  led_pattern_sequencer_if.slave   req,
  input  logic                     pause,
`ifdef LED_SEQ_PWM_EN
  input  logic [3:0]               brightness,
`endif
  output logic                     step_tick,
  output logic [LED_W-1:0]         led
);

  hs_state_t          r_state;
  hs_state_t          w_state_next;
  logic               w_ready;
  logic               w_accept;
  logic               w_apply;
  logic               w_fire;

  logic [MODE_W-1:0]  r_pend_mode;
  logic [SPEED_W-1:0] r_pend_speed;
  logic [MODE_W-1:0]  r_mode;
  logic [SPEED_W-1:0] r_speed;
  logic [LED_W-1:0]   r_pattern;
  logic [LED_W-1:0]   w_pat_next;
  logic               r_dir_up;
  logic               w_dir_next;

  led_step_prescaler #(
    .STEP_DIV (STEP_DIV),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .pause     (pause),
    .speed     (r_speed),
    .fire      (w_fire),
    .step_tick (step_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_accept     = 1'b0;
    w_apply      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (req.mode_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (w_fire) begin
          w_apply      = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign req.mode_ready = w_ready;

  // An apply step loads the new initial pattern instead of advancing.
  always_comb begin
    w_pat_next = r_pattern;
    w_dir_next = r_dir_up;
    if (w_apply) begin
      w_pat_next = pattern_init(r_pend_mode);
      w_dir_next = 1'b1;
    end else if (w_fire) begin
      case (r_mode)
        MODE_BLINK: w_pat_next = ~r_pattern;
        MODE_CHASE: w_pat_next = {r_pattern[LED_W-2:0], r_pattern[LED_W-1]};
        MODE_BOUNCE: begin
          if (r_dir_up) begin
            if (r_pattern == PAT_BOUNCE_TOP) begin
              w_pat_next = r_pattern >> 1;
              w_dir_next = 1'b0;
            end else begin
              w_pat_next = r_pattern << 1;
            end
          end else begin
            if (r_pattern == PAT_BOUNCE_BOT) begin
              w_pat_next = r_pattern << 1;
              w_dir_next = 1'b1;
            end else begin
              w_pat_next = r_pattern >> 1;
            end
          end
        end
        MODE_COUNT: w_pat_next = r_pattern + 4'd1;
        default:    w_pat_next = PAT_OFF_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_mode  <= MODE_OFF;
      r_pend_speed <= '0;
      r_mode       <= MODE_OFF;
      r_speed      <= '0;
      r_pattern    <= PAT_OFF_INIT;
      r_dir_up     <= 1'b1;
    end else begin
      r_pattern <= w_pat_next;
      r_dir_up  <= w_dir_next;
      if (w_accept) begin
        r_pend_mode  <= req.mode_in;
        r_pend_speed <= req.speed_in;
      end
      if (w_apply) begin
        r_mode  <= r_pend_mode;
        r_speed <= r_pend_speed;
      end
    end
  end

`ifdef LED_SEQ_PWM_EN
  logic [3:0] r_pwm_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pwm_cnt <= 4'd0;
    else     r_pwm_cnt <= r_pwm_cnt + 4'd1;
  end

  assign led = r_pattern & {LED_W{r_pwm_cnt < brightness}};
`else
  assign led = r_pattern;
`endif

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_led_pattern_sequencer                                           |
// | Scoreboard bench for led_pattern_sequencer with STEP_DIV = 8.      |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_led_pattern_sequencer;
  import led_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pause = 1'b0;
  logic       step_tick;
  logic [3:0] led;
`ifdef LED_SEQ_PWM_EN
  logic [3:0] brightness = 4'd15;
  logic [3:0] tb_pwm;
`endif

  int checks = 0;
  int errors = 0;
  logic [3:0] pat_q[$];
  logic [3:0] cur_pat = 4'b0000;

  led_pattern_sequencer_if rq ();

  led_pattern_sequencer #(.STEP_DIV(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (rq),
    .pause      (pause),
`ifdef LED_SEQ_PWM_EN
    .brightness (brightness),
`endif
    .step_tick  (step_tick),
    .led        (led)
  );

  always #5 clk = ~clk;

`ifdef LED_SEQ_PWM_EN
  always @(posedge clk or posedge rst) begin
    if (rst) tb_pwm <= 4'd0;
    else     tb_pwm <= tb_pwm + 4'd1;
  end
`endif

  function automatic logic [3:0] exp_led(input logic [3:0] p);
`ifdef LED_SEQ_PWM_EN
    return p & {4{tb_pwm < brightness}};
`else
    return p;
`endif
  endfunction

  // Issue one request from a negedge; return cycles mode_ready stayed low.
  task automatic send_req(input logic [2:0] m, input logic [1:0] s,
                          output int lat, output bit ok);
    int n;
    ok = 1'b0;
    lat = 0;
    n = 0;
    while (!rq.mode_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    rq.mode_in    = m;
    rq.speed_in   = s;
    rq.mode_valid = 1'b1;
    @(negedge clk);
    rq.mode_valid = 1'b0;
    while (lat < 50) begin
      if (rq.mode_ready) begin
        ok = 1'b1;
        break;
      end
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (led !== 4'b0000 || step_tick !== 1'b0 || rq.mode_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state led=%b tick=%b ready=%b expected 0000 0 1",
               led, step_tick, rq.mode_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    int ticks = 0;
    int next_tick = 8;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      checks++;
      if (led !== 4'b0000 || rq.mode_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_led cyc=%0d led=%b ready=%b expected 0000 1", i, led, rq.mode_ready);
      end
      if (step_tick) begin
        checks++;
        if (i != next_tick) begin
          errors++;
          $display("FAIL idle_tick_spacing tick at %0d expected %0d", i, next_tick);
        end
        ticks++;
        next_tick = i + 8;
      end
    end
    checks++;
    if (ticks != 5) begin
      errors++;
      $display("FAIL idle_tick_count got %0d expected 5", ticks);
    end
  endtask

  task automatic test_chase();
    int lat, cyc, budget;
    bit ok, first;
    logic [3:0] e;
    send_req(MODE_CHASE, 2'd0, lat, ok);
    checks++;
    if (!ok || lat < 1 || lat > 9) begin
      errors++;
      $display("FAIL chase_ready_low ok=%0d low=%0d expected 1..9", ok, lat);
    end
    pat_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    cyc = 0; budget = 0; first = 1'b1;
    while (pat_q.size() > 0 && budget < 400) begin
      if (step_tick) begin
        e = pat_q.pop_front();
        checks++;
        if (led !== exp_led(e) || (!first && cyc != 8)) begin
          errors++;
          $display("FAIL chase_step led=%b gap=%0d expected led=%b gap=8", led, cyc, exp_led(e));
        end
        first = 1'b0; cyc = 0; cur_pat = e;
        if (pat_q.size() == 0) break;
      end
      @(negedge clk); cyc++; budget++;
    end
    checks++;
    if (pat_q.size() != 0) begin
      errors++;
      $display("FAIL chase_timeout left=%0d expected 0", pat_q.size());
    end
  endtask

  task automatic test_bounce();
    int lat, cyc, budget;
    bit ok, first;
    logic [3:0] e;
    send_req(MODE_BOUNCE, 2'd1, lat, ok);
    checks++;
    if (!ok || lat < 1 || lat > 9) begin
      errors++;
      $display("FAIL bounce_ready_low ok=%0d low=%0d expected 1..9", ok, lat);
    end
    pat_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    cyc = 0; budget = 0; first = 1'b1;
    while (pat_q.size() > 0 && budget < 400) begin
      if (step_tick) begin
        e = pat_q.pop_front();
        checks++;
        if (led !== exp_led(e) || (!first && cyc != 4)) begin
          errors++;
          $display("FAIL bounce_step led=%b gap=%0d expected led=%b gap=4", led, cyc, exp_led(e));
        end
        first = 1'b0; cyc = 0; cur_pat = e;
        if (pat_q.size() == 0) break;
      end
      @(negedge clk); cyc++; budget++;
    end
    checks++;
    if (pat_q.size() != 0) begin
      errors++;
      $display("FAIL bounce_timeout left=%0d expected 0", pat_q.size());
    end
  endtask

  task automatic test_count_pause();
    int lat, cyc, budget;
    bit ok, first;
    logic [3:0] e;
    send_req(MODE_COUNT, 2'd3, lat, ok);
    checks++;
    if (!ok || lat < 1 || lat > 5) begin
      errors++;
      $display("FAIL count_ready_low ok=%0d low=%0d expected 1..5", ok, lat);
    end
    pat_q.delete();
    for (int i = 0; i < 19; i++) pat_q.push_back(4'(i));
    cyc = 0; budget = 0; first = 1'b1;
    while (pat_q.size() > 0 && budget < 400) begin
      if (step_tick) begin
        e = pat_q.pop_front();
        checks++;
        if (led !== exp_led(e) || (!first && cyc != 1)) begin
          errors++;
          $display("FAIL count_step led=%b gap=%0d expected led=%b gap=1", led, cyc, exp_led(e));
        end
        first = 1'b0; cyc = 0; cur_pat = e;
        if (pat_q.size() == 0) break;
      end
      @(negedge clk); cyc++; budget++;
    end
    checks++;
    if (pat_q.size() != 0) begin
      errors++;
      $display("FAIL count_timeout left=%0d expected 0", pat_q.size());
    end

    pause = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checks++;
      if (step_tick !== 1'b0 || led !== exp_led(cur_pat)) begin
        errors++;
        $display("FAIL pause_hold cyc=%0d tick=%b led=%b expected 0 %b",
                 i, step_tick, led, exp_led(cur_pat));
      end
      if (i >= 6) begin
        checks++;
        if (rq.mode_ready !== 1'b0) begin
          errors++;
          $display("FAIL pause_pending cyc=%0d ready=%b expected 0", i, rq.mode_ready);
        end
      end
      if (i == 5) begin
        rq.mode_in = MODE_BLINK; rq.speed_in = 2'd0; rq.mode_valid = 1'b1;
      end
      if (i == 6) rq.mode_valid = 1'b0;
    end
    pause = 1'b0;

    pat_q = '{4'b1111, 4'b0000, 4'b1111};
    cyc = 0; budget = 0; first = 1'b1;
    while (pat_q.size() > 0 && budget < 400) begin
      if (step_tick) begin
        e = pat_q.pop_front();
        checks++;
        if (led !== exp_led(e) || (!first && cyc != 8) || rq.mode_ready !== 1'b1) begin
          errors++;
          $display("FAIL blink_after_pause led=%b gap=%0d ready=%b expected led=%b gap=8 ready=1",
                   led, cyc, rq.mode_ready, exp_led(e));
        end
        first = 1'b0; cyc = 0; cur_pat = e;
        if (pat_q.size() == 0) break;
      end
      @(negedge clk); cyc++; budget++;
    end
    checks++;
    if (pat_q.size() != 0) begin
      errors++;
      $display("FAIL blink_timeout left=%0d expected 0", pat_q.size());
    end
  endtask

  task automatic test_speed_change();
    int lat, cyc, budget;
    bit ok, first;
    logic [3:0] e;
    send_req(MODE_COUNT, 2'd0, lat, ok);
    checks++;
    if (!ok || led !== exp_led(4'b0000)) begin
      errors++;
      $display("FAIL speed0_apply ok=%0d led=%b expected 1 %b", ok, led, exp_led(4'b0000));
    end
    repeat (6) @(negedge clk);
    send_req(MODE_COUNT, 2'd2, lat, ok);
    checks++;
    if (!ok || lat != 1 || step_tick !== 1'b1) begin
      errors++;
      $display("FAIL speed2_apply ok=%0d low=%0d tick=%b expected 1 1 1", ok, lat, step_tick);
    end
    pat_q = '{4'b0000, 4'b0001, 4'b0010};
    cyc = 0; budget = 0; first = 1'b1;
    while (pat_q.size() > 0 && budget < 400) begin
      if (step_tick) begin
        e = pat_q.pop_front();
        checks++;
        if (led !== exp_led(e) || (!first && cyc != 2)) begin
          errors++;
          $display("FAIL speed2_step led=%b gap=%0d expected led=%b gap=2", led, cyc, exp_led(e));
        end
        first = 1'b0; cyc = 0; cur_pat = e;
        if (pat_q.size() == 0) break;
      end
      @(negedge clk); cyc++; budget++;
    end
    checks++;
    if (pat_q.size() != 0) begin
      errors++;
      $display("FAIL speed2_timeout left=%0d expected 0", pat_q.size());
    end
  endtask

  task automatic test_async_reset();
    int ticks = 0;
    rq.mode_in = MODE_CHASE; rq.speed_in = 2'd0; rq.mode_valid = 1'b1;
    @(negedge clk);
    rq.mode_valid = 1'b0;
    checks++;
    if (rq.mode_ready !== 1'b0) begin
      errors++;
      $display("FAIL arst_pending ready=%b expected 0", rq.mode_ready);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (led !== 4'b0000 || rq.mode_ready !== 1'b1 || step_tick !== 1'b0) begin
      errors++;
      $display("FAIL arst_immediate led=%b ready=%b tick=%b expected 0000 1 0",
               led, rq.mode_ready, step_tick);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      checks++;
      if (led !== 4'b0000 || rq.mode_ready !== 1'b1 || step_tick !== (i == 8)) begin
        errors++;
        $display("FAIL arst_discard cyc=%0d led=%b ready=%b tick=%b expected 0000 1 %0d",
                 i, led, rq.mode_ready, step_tick, (i == 8));
      end
    end
  endtask

`ifdef LED_SEQ_PWM_EN
  task automatic test_pwm();
    int lat, on_cnt;
    bit ok;
    send_req(MODE_BLINK, 2'd0, lat, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL pwm_apply ok=%0d expected 1", ok);
    end
    pause = 1'b1;
    brightness = 4'd4;
    on_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (led == 4'b1111) on_cnt++;
      checks++;
      if (led !== exp_led(4'b1111)) begin
        errors++;
        $display("FAIL pwm_cycle cyc=%0d led=%b expected %b", i, led, exp_led(4'b1111));
      end
    end
    checks++;
    if (on_cnt != 4) begin
      errors++;
      $display("FAIL pwm_duty on=%0d expected 4", on_cnt);
    end
    brightness = 4'd0;
    on_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (led != 4'b0000) on_cnt++;
    end
    checks++;
    if (on_cnt != 0) begin
      errors++;
      $display("FAIL pwm_dark on=%0d expected 0", on_cnt);
    end
    pause = 1'b0;
    brightness = 4'd15;
  endtask
`endif

  initial begin
    rq.mode_in = 3'd0;
    rq.speed_in = 2'd0;
    rq.mode_valid = 1'b0;
    test_reset();
    test_idle();
    test_chase();
    test_bounce();
    test_count_pause();
    test_speed_change();
    test_async_reset();
`ifdef LED_SEQ_PWM_EN
    test_pwm();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
